// File: rtl/etapa_fetch.sv
// rtl/etapa_fetch.sv - instruction fetch stage: PC owner, req/ack memory port, 2-entry buffer, IF/ID output.
module etapa_fetch #(
  parameter int                  ADDR_W   = 8,
  parameter int                  INSTR_W  = 14,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [INSTR_W-1:0]  NOP      = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid
);

  typedef enum logic {S_FETCH, S_DISCARD} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, fetch_pc_adv;

  logic [INSTR_W-1:0] fifo_instr [2];
  logic [ADDR_W-1:0]  fifo_pc    [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         count_q, count_after;

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q;

  logic               xfer, push, pop, start;

  assign xfer = req_q && imem_ack;
  assign push = xfer && (state_q == S_FETCH) && !redirect;
  assign pop  = !stall && !redirect && (count_q != 2'd0);
  assign count_after  = count_q + {1'b0, push} - {1'b0, pop};
  assign fetch_pc_adv = push ? fetch_pc_q + 1'b1 : fetch_pc_q;

  // A new request only starts if its word is guaranteed a free slot after this edge.
  assign start = (state_q == S_FETCH) && !redirect && (!req_q || xfer) && (count_after != 2'd2);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_adv;
    if (xfer) begin
      req_d = 1'b0;
    end
    if (start) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_adv;
    end
    case (state_q)
      S_FETCH: begin
        if (redirect && req_q && !imem_ack) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (xfer) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (redirect) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_after;
    end
  end

  // Buffer payload needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]    <= addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (redirect) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (count_q != 2'd0) begin
        instr_q <= fifo_instr[rd_ptr_q];
        pc_q    <= fifo_pc[rd_ptr_q];
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP;
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_q;
  assign instr_valid     = valid_q;

endmodule
